// File: rtl/relay_pkg.sv
// Shared state encoding and link marker constants for the relay transmitter.
// No logic of its own; pure types, constants and marker helper functions.
// Start markers are 8 bits; end markers are left-aligned in a 32-bit word.
package relay_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_START,
    ST_DATA,
    ST_END
  } state_t;

  localparam logic [7:0]  READER_START = 8'hc0;
  localparam logic [7:0]  TAG_START    = 8'hf0;
  localparam logic [31:0] READER_END   = 32'hc0000000;
  localparam logic [23:0] TAG_END      = 24'h000000;

  // Width of the per-segment bit counter (holds bits remaining minus one).
  localparam int CNT_W = 8;

  // Start marker left-aligned in the 32-bit marker shift register.
  function automatic logic [31:0] start_word(input logic tag);
    return tag ? {TAG_START, 24'h000000} : {READER_START, 24'h000000};
  endfunction

  // End marker left-aligned in the 32-bit marker shift register.
  function automatic logic [31:0] end_word(input logic tag);
    return tag ? {TAG_END, 8'h00} : READER_END;
  endfunction

  // End marker length minus one (the first bit is emitted on load).
  function automatic logic [CNT_W-1:0] end_bits_m1(input logic tag);
    return tag ? CNT_W'(23) : CNT_W'(31);
  endfunction

endpackage

// File: rtl/relay_bit_clk.sv
// Free-running bit-period divider producing a one-cycle bit_edge strobe.
// Strobe is high in the last clock of each bit, so registers fed by it change as the divider wraps to 0.
// No backpressure: the divider never stalls.
module relay_bit_clk #(
  parameter int DIV_LOG2 = 4
) (
  input  logic clk,
  input  logic rst,
  output logic bit_edge
);

  logic [DIV_LOG2-1:0] div;

  // Divider counts continuously; its wrap marks each bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div <= '0;
    else     div <= div + DIV_LOG2'(1);
  end

  assign bit_edge = (div == '1);

endmodule

// File: rtl/relay_frame_tx.sv
// Relay link transmitter: frames ARM-side bytes as preamble, start marker, payload, end marker on relay_out.
// First payload bit appears (PREAMBLE_BITS+8) bit periods after the accepting bit edge; 1 bit per 2**BIT_DIV_LOG2 clocks.
// tx_ready pulses once per byte taken at byte boundaries; starving tx_valid ends the frame (underrun). Optional RELAY_ABORT_EN adds abort.
module relay_frame_tx
  import relay_pkg::*;
#(
  parameter int BIT_DIV_LOG2  = 4,
  parameter int PREAMBLE_BITS = 16
) (
  input  logic       ck_1356meg,
  input  logic       reset,
  input  logic       role,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  input  logic       tx_last,
`ifdef RELAY_ABORT_EN
  input  logic       abort,
`endif
  output logic       tx_ready,
  output logic       relay_out,
  output logic       busy,
  output logic       underrun
);

  state_t           state, state_n;
  logic             bit_edge;
  logic             role_q, role_n;
  logic [31:0]      mark_sr, mark_n;
  logic [7:0]       data_sr, data_n;
  logic             last_q, last_n;
  logic [CNT_W-1:0] bit_cnt, cnt_n;
  logic             out_n, busy_n, under_n;
  logic             load_byte, load_end;
  logic             abort_any;

  relay_bit_clk #(
    .DIV_LOG2 (BIT_DIV_LOG2)
  ) u_bit_clk (
    .clk      (ck_1356meg),
    .rst      (reset),
    .bit_edge (bit_edge)
  );

`ifdef RELAY_ABORT_EN
  logic abort_pend;
  logic in_frame;

  assign in_frame  = (state == ST_PRE) || (state == ST_START) || (state == ST_DATA);
  assign abort_any = in_frame && (abort || abort_pend);

  // Hold an abort until the bit or byte boundary where it redirects the frame to END.
  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) abort_pend <= 1'b0;
    else       abort_pend <= abort_any &&
                             ((state_n == ST_PRE) || (state_n == ST_START) || (state_n == ST_DATA));
  end
`else
  assign abort_any = 1'b0;
`endif

  // Next-state and datapath decisions; everything moves only on a bit edge.
  always_comb begin
    state_n   = state;
    role_n    = role_q;
    mark_n    = mark_sr;
    data_n    = data_sr;
    last_n    = last_q;
    cnt_n     = bit_cnt;
    out_n     = relay_out;
    busy_n    = busy;
    under_n   = underrun;
    tx_ready  = 1'b0;
    load_byte = 1'b0;
    load_end  = 1'b0;
    if (bit_edge) begin
      case (state)
        ST_IDLE: begin
          out_n = 1'b0;
          if (tx_valid) begin
            // Frame accepted: role is frozen here, the preamble starts (all zeros).
            state_n = ST_PRE;
            role_n  = role;
            under_n = 1'b0;
            busy_n  = 1'b1;
            mark_n  = '0;
            cnt_n   = CNT_W'(PREAMBLE_BITS - 1);
          end
        end
        ST_PRE, ST_START: begin
          if (abort_any) begin
            load_end = 1'b1;
          end else if (bit_cnt != '0) begin
            {out_n, mark_n} = {mark_sr, 1'b0};
            cnt_n           = bit_cnt - CNT_W'(1);
          end else if (state == ST_PRE) begin
            state_n         = ST_START;
            {out_n, mark_n} = {start_word(role_q), 1'b0};
            cnt_n           = CNT_W'(7);
          end else if (tx_valid) begin
            load_byte = 1'b1;
          end else begin
            under_n  = 1'b1;
            load_end = 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_cnt != '0) begin
            {out_n, data_n} = {data_sr, 1'b0};
            cnt_n           = bit_cnt - CNT_W'(1);
          end else if (last_q || abort_any) begin
            load_end = 1'b1;
          end else if (tx_valid) begin
            load_byte = 1'b1;
          end else begin
            under_n  = 1'b1;
            load_end = 1'b1;
          end
        end
        ST_END: begin
          if (bit_cnt != '0) begin
            {out_n, mark_n} = {mark_sr, 1'b0};
            cnt_n           = bit_cnt - CNT_W'(1);
          end else begin
            state_n = ST_IDLE;
            out_n   = 1'b0;
            busy_n  = 1'b0;
          end
        end
        default: begin
          state_n = ST_IDLE;
          out_n   = 1'b0;
          busy_n  = 1'b0;
        end
      endcase

      if (load_byte) begin
        tx_ready        = 1'b1;
        state_n         = ST_DATA;
        {out_n, data_n} = {tx_byte, 1'b0};
        last_n          = tx_last;
        cnt_n           = CNT_W'(7);
      end
      if (load_end) begin
        state_n         = ST_END;
        {out_n, mark_n} = {end_word(role_q), 1'b0};
        cnt_n           = end_bits_m1(role_q);
      end
    end
  end

  // State and datapath registers; async reset drops the line immediately.
  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      role_q    <= 1'b0;
      mark_sr   <= '0;
      data_sr   <= '0;
      last_q    <= 1'b0;
      bit_cnt   <= '0;
      relay_out <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_n;
      role_q    <= role_n;
      mark_sr   <= mark_n;
      data_sr   <= data_n;
      last_q    <= last_n;
      bit_cnt   <= cnt_n;
      relay_out <= out_n;
      busy      <= busy_n;
      underrun  <= under_n;
    end
  end

endmodule

// File: tb/tb_relay_frame_tx.sv
// Bench for relay_frame_tx: table-driven frames plus random frames checked against a bit-list model.
// Samples DUT outputs on the falling edge; drives inputs 1 time unit after the rising edge.
// Every wait is bounded; a timeout counts as a failure.
module tb_relay_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       role = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready, relay_out, busy, underrun;
`ifdef RELAY_ABORT_EN
  logic       abort = 1'b0;
`endif

  always #5 clk = ~clk;

  relay_frame_tx dut (
    .ck_1356meg (clk),
    .reset      (rst),
    .role       (role),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .tx_last    (tx_last),
`ifdef RELAY_ABORT_EN
    .abort      (abort),
`endif
    .tx_ready   (tx_ready),
    .relay_out  (relay_out),
    .busy       (busy),
    .underrun   (underrun)
  );

  typedef struct {
    bit              role;
    int              n;
    logic [3:0][7:0] bytes;
    int              starve;     // drop tx_valid after this many bytes taken (0 = never)
    int              abort_at;   // pulse abort partway through this byte (0 = never)
    bit              toggle;     // wiggle role while the frame runs
    int              gap;
    int              exp_nbits;  // -1: take from the model
    int              exp_ready;  // -1: take from the model
    int              exp_under;  // -1: take from the model
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   frame_no = 0;
  int   last_under = 0;
  bit   exp_q[$];
  logic tr_out[$];
  logic tr_busy[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s frame=%0d actual=%0d expected=%0d", name, frame_no, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit r, input int n, input logic [31:0] b, input int starve,
                              input int abort_at, input bit toggle, input int nbits,
                              input int rdy, input int under);
    vec_t v;
    v.role = r; v.n = n; v.bytes = b; v.starve = starve; v.abort_at = abort_at;
    v.toggle = toggle; v.gap = 7; v.exp_nbits = nbits; v.exp_ready = rdy; v.exp_under = under;
    return v;
  endfunction

  // Reference: the line carries preamble zeros, start byte, sent payload, end marker, MSB first.
  task automatic build_exp(input bit r, input logic [3:0][7:0] b, input int nsent);
    logic [7:0]  sm;
    logic [15:0] em;
    exp_q.delete();
    repeat (16) exp_q.push_back(1'b0);
    sm = r ? 8'hf0 : 8'hc0;
    for (int i = 7; i >= 0; i--) exp_q.push_back(sm[i]);
    for (int k = 0; k < nsent; k++)
      for (int i = 7; i >= 0; i--) exp_q.push_back(b[k][i]);
    if (r) begin
      repeat (24) exp_q.push_back(1'b0);
    end else begin
      em = 16'hc000;
      for (int i = 15; i >= 0; i--) exp_q.push_back(em[i]);
      repeat (16) exp_q.push_back(1'b0);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int idx = 0, rdy = 0, cyc = 0, a = -1, nb = 0, ones, nsent, since = 0;
    int exp_bits, exp_rdy, exp_und;
    bit seen = 0, done = 0, got;
    frame_no++;
    tr_out.delete();
    tr_busy.delete();
    chk("underrun_hold", underrun, last_under);
    role = v.role;
    repeat (v.gap) @(posedge clk);
    #1;
    tx_byte  = v.bytes[0];
    tx_last  = (v.n == 1);
    tx_valid = 1'b1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      tr_out.push_back(relay_out);
      tr_busy.push_back(busy);
      got = tx_ready;
      if (busy && !seen) begin
        seen = 1;
        chk("underrun_clear", underrun, 0);
      end
      if (seen && !busy) done = 1;
      @(posedge clk);
      #1;
      cyc++;
      if (v.toggle && seen) role = 1'($urandom_range(0, 1));
      if (got) begin
        rdy++;
        idx++;
        if (idx >= v.n || idx == v.starve) tx_valid = 1'b0;
        else begin
          tx_byte = v.bytes[idx];
          tx_last = (idx == v.n - 1);
        end
      end
`ifdef RELAY_ABORT_EN
      abort = 1'b0;
      if (v.abort_at > 0 && rdy == v.abort_at) begin
        since++;
        if (since == 40) abort = 1'b1;
      end
`endif
      if (done) tx_valid = 1'b0;
    end
    tx_valid = 1'b0;
    if (!done) chk("frame_timeout", 0, 1);

    nsent   = (v.abort_at > 0) ? v.abort_at : ((v.starve > 0 && v.starve < v.n) ? v.starve : v.n);
    build_exp(v.role, v.bytes, nsent);
    exp_bits = (v.exp_nbits >= 0) ? v.exp_nbits : exp_q.size();
    exp_rdy  = (v.exp_ready >= 0) ? v.exp_ready : nsent;
    exp_und  = (v.exp_under >= 0) ? v.exp_under
                                   : ((v.abort_at == 0 && v.starve > 0 && v.starve < v.n) ? 1 : 0);

    foreach (tr_busy[i]) if (tr_busy[i]) begin
      if (a < 0) a = i;
      nb++;
    end
    chk("busy_cycles", nb, 16 * exp_bits);
    if (a >= 0) begin
      for (int k = 0; k < exp_q.size(); k++) begin
        ones = 0;
        for (int j = 0; j < 16; j++)
          if (a + 16 * k + j < tr_out.size()) ones += int'(tr_out[a + 16 * k + j]);
        chk($sformatf("bit%0d_ones_in_16", k), ones, exp_q[k] ? 16 : 0);
      end
    end
    chk("tx_ready_pulses", rdy, exp_rdy);
    chk("underrun_end", underrun, exp_und);
    chk("idle_low", relay_out, 0);
    last_under = exp_und;
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   cyc;

    // Hand-derived frames: reader 1 byte, tag 3 bytes, underrun, clear-after-underrun, role wiggle.
    tbl.push_back(mk(0, 1, 32'h000000a5, 0, 0, 0, 64, 1, 0));
    tbl.push_back(mk(1, 3, 32'h00563412, 0, 0, 0, 72, 3, 0));
    tbl.push_back(mk(0, 3, 32'h00bbaa3c, 1, 0, 0, 64, 1, 1));
    tbl.push_back(mk(1, 1, 32'h00000081, 0, 0, 1, 56, 1, 0));
    tbl.push_back(mk(0, 2, 32'h00000ff0, 0, 0, 1, 72, 2, 0));
`ifdef RELAY_ABORT_EN
    tbl.push_back(mk(0, 4, 32'h44332211, 0, 2, 0, 72, 2, 0));
`endif

    repeat (2) @(negedge clk);
    chk("rst_relay_out", relay_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_underrun", underrun, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_frame(tbl[i]);

    // Reset in the middle of a payload byte of all ones.
    frame_no++;
    role = 1'b0; tx_byte = 8'hff; tx_last = 1'b1; tx_valid = 1'b1;
    cyc = 0;
    while (!busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rstseq_busy", busy, 1);
    repeat (27 * 16) @(posedge clk);
    @(negedge clk);
    chk("rstseq_data_high", relay_out, 1);
    rst = 1'b1;
    #1;
    chk("rstseq_out_async", relay_out, 0);
    chk("rstseq_busy_low", busy, 0);
    chk("rstseq_ready_low", tx_ready, 0);
    tx_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    last_under = 0;
    run_frame(tbl[0]);

    // Random frames against the model.
    for (int i = 0; i < 8; i++) begin
      v.role      = 1'($urandom_range(0, 1));
      v.n         = $urandom_range(1, 4);
      v.bytes     = $urandom;
      v.starve    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, v.n) : 0;
      v.abort_at  = 0;
      v.toggle    = 1;
      v.gap       = $urandom_range(0, 40);
      v.exp_nbits = -1;
      v.exp_ready = -1;
      v.exp_under = -1;
      run_frame(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
